// File: rtl/seg_display_regs.sv
// ---------------------------------------------------------------------------
// seg_display_regs
//
// Memory-mapped register block sitting between the CPU I/O bus and the
// seven-segment display driver. The CPU stages a 24-bit value in SHADOW and
// commits it atomically to the driver through COMMIT. CTRL gates the display
// and selects a hardware blink whose half-period is BLINK_DIV clock cycles.
// Every output toward the driver is registered.
//
// Register map (io_addr):
//   0 SHADOW  R/W  staged display value (bits 23:0)
//   1 CTRL    R/W  bit0 disp_en, bit1 blink_en
//   2 COMMIT  W    any write copies shadow to num, clears pending
//   3 STATUS  R    {pending, phase}
//
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   asynchronous active-low reset
//   io_wen    in   bus write strobe
//   io_ren    in   bus read strobe
//   io_addr   in   register offset
//   io_wdata  in   write data
//   io_rdata  out  combinational read data
//   num       out  committed display value to the driver
//   enable    out  display enable to the driver
// ---------------------------------------------------------------------------
module seg_display_regs #(
   parameter int unsigned BLINK_DIV = 25000000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        io_wen,
   input  logic        io_ren,
   input  logic [1:0]  io_addr,
   input  logic [31:0] io_wdata,
   output logic [31:0] io_rdata,
   output logic [23:0] num,
   output logic        enable
);

   localparam logic [1:0]  ADDR_SHADOW = 2'd0;
   localparam logic [1:0]  ADDR_CTRL   = 2'd1;
   localparam logic [1:0]  ADDR_COMMIT = 2'd2;
   localparam logic [1:0]  ADDR_STATUS = 2'd3;
   localparam logic [25:0] BCNT_LAST   = 26'(BLINK_DIV - 1);

   logic [23:0] shadow,   shadow_n;
   logic [23:0] num_n;
   logic        disp_en,  disp_en_n;
   logic        blink_en, blink_en_n;
   logic [25:0] bcnt,     bcnt_n;
   logic        phase,    phase_n;
   logic        pending,  pending_n;
   logic        enable_n;

   // Upper write-data bits carry no meaning in any register.
   logic wdata_unused;
   assign wdata_unused = ^io_wdata[31:24];

   // Next-state computation for all registers. Bus writes are decoded
   // first, then the blink engine runs off the already-updated blink_en so
   // that a CTRL write and the enable it produces land on the same edge.
   always_comb begin
      shadow_n   = shadow;
      num_n      = num;
      disp_en_n  = disp_en;
      blink_en_n = blink_en;
      pending_n  = pending;
      bcnt_n     = bcnt;
      phase_n    = phase;

      if (io_wen) begin
         case (io_addr)
            ADDR_SHADOW: begin
               shadow_n  = io_wdata[23:0];
               pending_n = 1'b1;
            end
            ADDR_CTRL: begin
               disp_en_n  = io_wdata[0];
               blink_en_n = io_wdata[1];
            end
            ADDR_COMMIT: begin
               num_n     = shadow;
               pending_n = 1'b0;
            end
            default: begin
            end
         endcase
      end

      // A 0->1 transition of blink_en restarts the engine in the "on" phase;
      // keeping blink_en high leaves the running count alone.
      if (!blink_en_n || !blink_en) begin
         bcnt_n  = '0;
         phase_n = 1'b1;
      end else if (bcnt == BCNT_LAST) begin
         bcnt_n  = '0;
         phase_n = ~phase;
      end else begin
         bcnt_n  = bcnt + 26'd1;
      end

      enable_n = disp_en_n & (~blink_en_n | phase_n);
   end

   // State and output registers; reset parks the engine in the "on" phase
   // with the display disabled.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         shadow   <= '0;
         num      <= '0;
         disp_en  <= 1'b0;
         blink_en <= 1'b0;
         pending  <= 1'b0;
         bcnt     <= '0;
         phase    <= 1'b1;
         enable   <= 1'b0;
      end else begin
         shadow   <= shadow_n;
         num      <= num_n;
         disp_en  <= disp_en_n;
         blink_en <= blink_en_n;
         pending  <= pending_n;
         bcnt     <= bcnt_n;
         phase    <= phase_n;
         enable   <= enable_n;
      end
   end

   // Zero-latency read mux. A write in the same cycle takes priority and
   // suppresses the read; reset also forces zero.
   always_comb begin
      io_rdata = '0;
      if (rst && io_ren && !io_wen) begin
         case (io_addr)
            ADDR_SHADOW: io_rdata = {8'h0, shadow};
            ADDR_CTRL:   io_rdata = {30'h0, blink_en, disp_en};
            ADDR_STATUS: io_rdata = {30'h0, pending, phase};
            default:     io_rdata = '0;
         endcase
      end
   end

endmodule

// File: doc/seg_display_regs.md
# seg_display_regs

Memory-mapped register block between the CPU's I/O bus and the seven-segment display driver. The CPU stages a 24-bit value in a shadow register and commits it atomically to the driver's `num` input. A control register gates the driver's `enable` and selects an optional hardware blink. Every output is registered, so the driver never sees a partially written value.

## Interface
- `BLINK_DIV`, default 25000000: blink half-period in `clk` cycles; legal range 2 to 2^26.
- `clk`  in  1  system clock; all state is updated on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `io_wen`  in  1  bus write strobe, one cycle per write.
- `io_ren`  in  1  bus read strobe.
- `io_addr`  in  2  register offset: 0 SHADOW, 1 CTRL, 2 COMMIT, 3 STATUS.
- `io_wdata`  in  32  write data.
- `io_rdata`  out  32  read data, combinational.
- `num`  out  24  committed display value, to the driver.
- `enable`  out  1  display enable, to the driver.

## Operation
- SHADOW (offset 0, R/W):
  - A write loads `io_wdata[23:0]` and ignores bits 31:24.
  - A read returns `{8'h0, shadow}`.
  - A write sets `pending`.
- CTRL (offset 1, R/W):
  - Bit 0 is `disp_en`, bit 1 is `blink_en`; other write bits are ignored.
  - A read returns `{30'h0, blink_en, disp_en}`.
- COMMIT (offset 2, write-only):
  - A write with any data copies shadow to `num` and clears `pending`.
  - A read returns 0.
- STATUS (offset 3, read-only):
  - A read returns `{30'h0, pending, phase}`.
  - A write has no effect.
- Blink engine, with a 26-bit counter `bcnt` and a 1-bit `phase`:
  - `blink_en`=0: `bcnt` is held at 0 and `phase` at 1.
  - `blink_en`=1: `bcnt` counts 0..BLINK_DIV-1. At the edge where `bcnt`==BLINK_DIV-1, `bcnt` goes to 0 and `phase` toggles.
  - A CTRL write that changes `blink_en` from 0 to 1 restarts the engine: `bcnt`=0, `phase`=1.
  - A CTRL write that keeps `blink_en`=1 does not disturb the counter.
- `enable` is registered: next value = `disp_en & (~blink_en | phase)`, evaluated from the next-state values.
- `io_rdata` = 0 whenever `io_ren`=0, or when `io_ren`=1 and `io_wen`=1 in the same cycle (the write wins; the read is ignored).
- Only one register is accessed per cycle, so register writes never collide with each other.
- Committing while `pending`=0 is legal: it rewrites `num` with the same shadow value.

## Timing
- Reset (`rst`=0, asynchronous) forces:
  - `shadow`=0, `num`=0
  - `disp_en`=0, `blink_en`=0, so `enable`=0
  - `bcnt`=0, `phase`=1, `pending`=0
  - `io_rdata`=0 (read strobe is ignored during reset)
- Deasserting `rst` takes effect at the next rising edge; the first legal access is in the cycle after `rst` goes high.
- Write latency: register contents, `num` and `enable` all update at the same rising edge that samples `io_wen`=1.
- Read latency: zero. `io_rdata` reflects current register state in the strobe cycle, and a read in the cycle after a write returns the new value.
- Blink period: `enable` toggles every BLINK_DIV cycles (full period 2·BLINK_DIV).
  - First falling transition comes BLINK_DIV edges after the enabling CTRL write.
- Wrap-around: `bcnt` never reaches BLINK_DIV.
- Writing CTRL with `blink_en`=0 while `phase`=0 restores `enable`=`disp_en` at that same edge.
- Reset asserted mid-blink or mid-sequence clears everything immediately; no commit survives a reset.

## Test plan
- Reset: hold `rst`=0 with random bus activity -> `num`=0, `enable`=0, STATUS read gives 32'h1 after release.
- Staged commit:
  - Write SHADOW=32'hFF12_3456 -> `num` stays 0, STATUS=32'h3, SHADOW reads 32'h0012_3456.
  - Write COMMIT -> `num`=24'h123456 at that edge, STATUS=32'h1.
- Enable: write CTRL=1 -> `enable`=1 at that edge; write CTRL=0 -> `enable`=0.
- Blink with BLINK_DIV=4, CTRL=3 written at edge T -> `enable`=1 until edge T+4, 0 for 4 cycles, 1 again at T+8. Then write CTRL=1 during the off phase -> `enable`=1 at that edge and STATUS bit0=1.
- Read/write rules:
  - Simultaneous `io_wen`/`io_ren` to SHADOW with data 32'hABCDEF -> `io_rdata`=0, shadow updated.
  - Write STATUS -> no state change.
  - Read COMMIT -> 0.
- Reset mid-operation: SHADOW write then `rst` pulse before COMMIT -> `num`=0, `pending`=0, SHADOW reads 0.
